// File: rtl/ddr3_axi_pkg.sv
// Shared AXI4 constants and FSM state type for the DDR3 stream writer.
package ddr3_axi_pkg;

    localparam logic [2:0] AXI_SIZE_4B       = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;
    localparam logic [3:0] AXI_CACHE_BUF_MOD = 4'b0011;
    localparam int unsigned PAGE_4K          = 4096;

    typedef enum logic [2:0] {
        StIdle,
        StCalc,
        StWaitFill,
        StAddr,
        StData,
        StResp
    } wr_state_e;

endpackage

// File: rtl/ddr3_wr_fifo.sv
// Synchronous data FIFO with occupancy count; push while full is accepted when a pop occurs
// in the same cycle.
module ddr3_wr_fifo
    import ddr3_axi_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 32,
    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [PW:0]      count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PW:0]      count_q;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (PW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/ddr3_stream_writer.sv
// AXI4 write master turning a 32-bit word stream into 4KB-safe INCR bursts.
// Optional counters enabled by DDR3_STREAM_WRITER_PERF_EN.
module ddr3_stream_writer
    import ddr3_axi_pkg::*;
#(
    parameter int unsigned BURST_LEN  = 16,
    parameter int unsigned FIFO_DEPTH = 32,
    parameter logic        ID_VAL     = 1'b0
) (
    input  logic        clk,
    input  logic        aresetn,
    input  logic        phy_init_done,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_addr,
    input  logic [15:0] cmd_beats,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    output logic        busy,
    output logic        done,
    output logic        err,
`ifdef DDR3_STREAM_WRITER_PERF_EN
    output logic [31:0] perf_busy_cycles,
    output logic [31:0] perf_stall_cycles,
`endif
    output logic        m_axi_awid,
    output logic [31:0] m_axi_awaddr,
    output logic [7:0]  m_axi_awlen,
    output logic [2:0]  m_axi_awsize,
    output logic [1:0]  m_axi_awburst,
    output logic        m_axi_awlock,
    output logic [3:0]  m_axi_awcache,
    output logic [2:0]  m_axi_awprot,
    output logic [3:0]  m_axi_awqos,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wlast,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic        m_axi_bid,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready
);

    localparam int unsigned CW = ((FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1) + 1;

    wr_state_e   state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] remaining_q, remaining_d;
    logic [15:0] stream_left_q, stream_left_d;
    logic [8:0]  blen_q, blen_d, beat_q, beat_d;
    logic        err_q, err_d, done_q, done_d, init_q;
    logic [CW-1:0] fifo_count;
    logic        fifo_full, fifo_empty, push, pop, cmd_fire;
    logic [15:0] page_left, blen_calc;

    assign cmd_ready = init_q & (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    // Stop taking words once the job's full count has been accepted.
    assign s_ready   = busy & ~fifo_full & (stream_left_q != '0);
    assign push      = s_valid & s_ready;
    assign pop       = m_axi_wvalid & m_axi_wready;
    assign cmd_fire  = cmd_valid & cmd_ready;
    assign done      = done_q;
    assign err       = err_q;

    assign m_axi_awid    = ID_VAL;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = 8'(blen_q - 9'd1);
    assign m_axi_awsize  = AXI_SIZE_4B;
    assign m_axi_awburst = AXI_BURST_INCR;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = AXI_CACHE_BUF_MOD;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awqos   = 4'b0000;
    assign m_axi_awvalid = (state_q == StAddr);
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_wvalid  = (state_q == StData);
    assign m_axi_wlast   = m_axi_wvalid & (beat_q == blen_q - 9'd1);
    assign m_axi_bready  = (state_q == StResp);

    // Words left before the next 4KB page boundary.
    assign page_left = 16'((13'(PAGE_4K) - {1'b0, addr_q[11:0]}) >> 2);

    ddr3_wr_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (aresetn),
        .push  (push),
        .wdata (s_data),
        .pop   (pop),
        .rdata (m_axi_wdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        blen_calc = remaining_q;
        if (blen_calc > 16'(BURST_LEN)) blen_calc = 16'(BURST_LEN);
        if (blen_calc > page_left)      blen_calc = page_left;
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        remaining_d   = remaining_q;
        stream_left_d = push ? stream_left_q - 16'd1 : stream_left_q;
        blen_d        = blen_q;
        beat_d        = beat_q;
        err_d         = err_q;
        done_d        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cmd_fire) begin
                    addr_d        = {cmd_addr[31:2], 2'b00};
                    remaining_d   = cmd_beats;
                    stream_left_d = cmd_beats;
                    err_d         = 1'b0;
                    if (cmd_beats == '0) done_d  = 1'b1;
                    else                 state_d = StCalc;
                end
            end
            StCalc: begin
                blen_d  = blen_calc[8:0];
                beat_d  = '0;
                state_d = StWaitFill;
            end
            StWaitFill: begin
                // Whole burst buffered first so WVALID never drops mid-burst.
                if (32'(fifo_count) >= 32'(blen_q) && phy_init_done) state_d = StAddr;
            end
            StAddr: begin
                if (m_axi_awready) state_d = StData;
            end
            StData: begin
                if (pop) begin
                    if (m_axi_wlast) state_d = StResp;
                    else             beat_d  = beat_q + 9'd1;
                end
            end
            StResp: begin
                if (m_axi_bvalid) begin
                    err_d       = err_q | (m_axi_bresp != AXI_RESP_OKAY);
                    addr_d      = addr_q + {21'd0, blen_q, 2'b00};
                    remaining_d = remaining_q - 16'(blen_q);
                    if (remaining_q == 16'(blen_q)) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        state_d = StCalc;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= StIdle;
            addr_q        <= '0;
            remaining_q   <= '0;
            stream_left_q <= '0;
            blen_q        <= '0;
            beat_q        <= '0;
            err_q         <= 1'b0;
            done_q        <= 1'b0;
            init_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            remaining_q   <= remaining_d;
            stream_left_q <= stream_left_d;
            blen_q        <= blen_d;
            beat_q        <= beat_d;
            err_q         <= err_d;
            done_q        <= done_d;
            init_q        <= 1'b1;
        end
    end

`ifdef DDR3_STREAM_WRITER_PERF_EN
    logic [31:0] perf_busy_q, perf_stall_q;
    logic        stall;

    assign stall = (m_axi_awvalid & ~m_axi_awready) | (m_axi_wvalid & ~m_axi_wready);

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            perf_busy_q  <= '0;
            perf_stall_q <= '0;
        end else if (cmd_fire) begin
            perf_busy_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            if (busy && perf_busy_q != '1)   perf_busy_q  <= perf_busy_q + 32'd1;
            if (stall && perf_stall_q != '1) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_busy_cycles  = perf_busy_q;
    assign perf_stall_cycles = perf_stall_q;
`endif

    logic unused_sig;
    assign unused_sig = ^{m_axi_bid, fifo_empty, blen_calc[15:9]};

endmodule

// File: tb/tb_ddr3_stream_writer.sv
// Directed bench for ddr3_stream_writer: AXI slave model with optional random backpressure.
`timescale 1ns/1ps
module tb_ddr3_stream_writer;

    localparam logic [31:0] SRC_BASE = 32'hA000_0000;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        phy_init_done = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr = '0;
    logic [15:0] cmd_beats = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = '0;
    logic        busy, done, err;
    logic        m_axi_awid;
    logic [31:0] m_axi_awaddr;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic        m_axi_awlock;
    logic [3:0]  m_axi_awcache;
    logic [2:0]  m_axi_awprot;
    logic [3:0]  m_axi_awqos;
    logic        m_axi_awvalid;
    logic        m_axi_awready = 1'b0;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wlast, m_axi_wvalid;
    logic        m_axi_wready = 1'b0;
    logic        m_axi_bid = 1'b0;
    logic [1:0]  m_axi_bresp = 2'b00;
    logic        m_axi_bvalid = 1'b0;
    logic        m_axi_bready;
`ifdef DDR3_STREAM_WRITER_PERF_EN
    logic [31:0] perf_busy_cycles, perf_stall_cycles;
`endif

    ddr3_stream_writer #(
        .BURST_LEN  (16),
        .FIFO_DEPTH (32),
        .ID_VAL     (1'b0)
    ) dut (
        .clk               (clk),
        .aresetn           (aresetn),
        .phy_init_done     (phy_init_done),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_addr          (cmd_addr),
        .cmd_beats         (cmd_beats),
        .s_valid           (s_valid),
        .s_ready           (s_ready),
        .s_data            (s_data),
        .busy              (busy),
        .done              (done),
        .err               (err),
`ifdef DDR3_STREAM_WRITER_PERF_EN
        .perf_busy_cycles  (perf_busy_cycles),
        .perf_stall_cycles (perf_stall_cycles),
`endif
        .m_axi_awid        (m_axi_awid),
        .m_axi_awaddr      (m_axi_awaddr),
        .m_axi_awlen       (m_axi_awlen),
        .m_axi_awsize      (m_axi_awsize),
        .m_axi_awburst     (m_axi_awburst),
        .m_axi_awlock      (m_axi_awlock),
        .m_axi_awcache     (m_axi_awcache),
        .m_axi_awprot      (m_axi_awprot),
        .m_axi_awqos       (m_axi_awqos),
        .m_axi_awvalid     (m_axi_awvalid),
        .m_axi_awready     (m_axi_awready),
        .m_axi_wdata       (m_axi_wdata),
        .m_axi_wstrb       (m_axi_wstrb),
        .m_axi_wlast       (m_axi_wlast),
        .m_axi_wvalid      (m_axi_wvalid),
        .m_axi_wready      (m_axi_wready),
        .m_axi_bid         (m_axi_bid),
        .m_axi_bresp       (m_axi_bresp),
        .m_axi_bvalid      (m_axi_bvalid),
        .m_axi_bready      (m_axi_bready)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Slave-model log, updated on the falling edge for the handshake at the next rising edge.
    int          aw_cnt, w_cnt, wlast_cnt, b_cnt, done_cnt;
    int          data_err, stab_err, order_err, awv_cycles, pending_b, src_idx;
    int          err_burst = -1;
    logic        src_en = 1'b0;
    logic        rnd_en = 1'b0;
    logic        aw_stall = 1'b0;
    logic        b_fired = 1'b0;
    logic [31:0] prev_awaddr;
    logic [7:0]  prev_awlen;
    logic [31:0] aw_addr_log[$];
    logic [7:0]  aw_len_log[$];

    always @(negedge clk) begin
        if (!aresetn) begin
            m_axi_awready = 1'b0;
            m_axi_wready  = 1'b0;
            m_axi_bvalid  = 1'b0;
            m_axi_bresp   = 2'b00;
            s_valid       = 1'b0;
            pending_b     = 0;
            aw_stall      = 1'b0;
            b_fired       = 1'b0;
        end else begin
            if (done) done_cnt++;
            // AW: payload must hold while stalled, valid must not drop
            if (m_axi_awvalid) begin
                awv_cycles++;
                if (aw_stall && (m_axi_awaddr !== prev_awaddr || m_axi_awlen !== prev_awlen))
                    stab_err++;
            end else if (aw_stall) begin
                stab_err++;
            end
            m_axi_awready = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
            if (m_axi_awvalid && m_axi_awready) begin
                aw_addr_log.push_back(m_axi_awaddr);
                aw_len_log.push_back(m_axi_awlen);
                aw_cnt++;
                aw_stall = 1'b0;
            end else begin
                aw_stall    = m_axi_awvalid;
                prev_awaddr = m_axi_awaddr;
                prev_awlen  = m_axi_awlen;
            end
            // B before W so a response never lands on its own WLAST edge
            if (b_fired) begin
                m_axi_bvalid = 1'b0;
                b_fired      = 1'b0;
            end
            if (!m_axi_bvalid && pending_b > 0 && (!rnd_en || $urandom_range(0, 1) == 1)) begin
                m_axi_bvalid = 1'b1;
                m_axi_bresp  = (b_cnt == err_burst) ? 2'b10 : 2'b00;
            end
            if (m_axi_bvalid && m_axi_bready) begin
                b_cnt++;
                pending_b--;
                b_fired = 1'b1;
            end
            if (m_axi_wvalid && aw_cnt <= wlast_cnt) order_err++;
            m_axi_wready = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
            if (m_axi_wvalid && m_axi_wready) begin
                if (m_axi_wdata !== SRC_BASE + 32'(w_cnt)) data_err++;
                if (m_axi_wlast) begin
                    wlast_cnt++;
                    pending_b++;
                end
                w_cnt++;
            end
            if (src_en) begin
                s_valid = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
                s_data  = SRC_BASE + 32'(src_idx);
                if (s_valid && s_ready) src_idx++;
            end else begin
                s_valid = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_log();
        aw_cnt = 0; w_cnt = 0; wlast_cnt = 0; b_cnt = 0; done_cnt = 0;
        data_err = 0; stab_err = 0; order_err = 0; awv_cycles = 0; src_idx = 0;
        aw_addr_log.delete();
        aw_len_log.delete();
    endtask

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic start_cmd(input logic [31:0] a, input logic [15:0] b);
        int t = 0;
        cmd_addr  = a;
        cmd_beats = b;
        cmd_valid = 1'b1;
        while (!cmd_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n_vec++;
        if (t >= 50) begin
            n_err++;
            $display("FAIL cmd_accept: cmd_ready still %0b after %0d cycles, want 1", cmd_ready, t);
        end
    endtask

    task automatic wait_done(input int budget);
        int t = 0;
        while (done_cnt == 0 && t < budget) begin
            @(posedge clk); #1;
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (done_cnt !== 1) begin
            n_err++;
            $display("FAIL done_count: got %0d pulses, want 1", done_cnt);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, busy, done, err, cmd_ready, s_ready}
            !== 8'h00) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want 00000000", {m_axi_awvalid, m_axi_wvalid,
                     m_axi_bready, busy, done, err, cmd_ready, s_ready});
        end
        aresetn = 1'b1;
        #1;
        n_vec++;
        if (cmd_ready !== 1'b0) begin
            n_err++;
            $display("FAIL cmd_ready_at_release: got %b want 0", cmd_ready);
        end
        @(posedge clk); #1;
        n_vec++;
        if (cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL cmd_ready_after_1: got %b want 1", cmd_ready);
        end
        phy_init_done = 1'b1;
        src_en        = 1'b1;
    endtask

    task automatic test_multi_burst();
        clear_log();
        start_cmd(32'hBC00_0000, 16'd40);
        n_vec++;
        if ({m_axi_awid, m_axi_awsize, m_axi_awburst, m_axi_awlock, m_axi_awcache, m_axi_awprot,
             m_axi_awqos, m_axi_wstrb} !== {1'b0, 3'b010, 2'b01, 1'b0, 4'b0011, 3'b000, 4'h0, 4'hF})
        begin
            n_err++;
            $display("FAIL aw_constants: got %h want %h", {m_axi_awid, m_axi_awsize, m_axi_awburst,
                     m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_wstrb},
                     {1'b0, 3'b010, 2'b01, 1'b0, 4'b0011, 3'b000, 4'h0, 4'hF});
        end
        wait_done(600);
        n_vec++;
        if (aw_cnt !== 3) begin
            n_err++; $display("FAIL multi_aw_cnt: got %0d want 3", aw_cnt);
        end
        n_vec++;
        if ({aw_addr_log[0], aw_addr_log[1], aw_addr_log[2]} !==
            {32'hBC00_0000, 32'hBC00_0040, 32'hBC00_0080}) begin
            n_err++;
            $display("FAIL multi_awaddr: got %h %h %h want bc000000 bc000040 bc000080",
                     aw_addr_log[0], aw_addr_log[1], aw_addr_log[2]);
        end
        n_vec++;
        if ({aw_len_log[0], aw_len_log[1], aw_len_log[2]} !== {8'd15, 8'd15, 8'd7}) begin
            n_err++;
            $display("FAIL multi_awlen: got %0d %0d %0d want 15 15 7",
                     aw_len_log[0], aw_len_log[1], aw_len_log[2]);
        end
        n_vec++;
        if (w_cnt !== 40 || data_err !== 0 || wlast_cnt !== 3) begin
            n_err++;
            $display("FAIL multi_wdata: got beats=%0d bad=%0d wlast=%0d want 40 0 3",
                     w_cnt, data_err, wlast_cnt);
        end
        n_vec++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL multi_end_state: got err=%b busy=%b want 0 0", err, busy);
        end
    endtask

    task automatic test_4k_boundary();
        clear_log();
        start_cmd(32'hBC00_0FF0, 16'd8);
        wait_done(300);
        n_vec++;
        if (aw_cnt !== 2 || {aw_addr_log[0], aw_addr_log[1]} !== {32'hBC00_0FF0, 32'hBC00_1000})
        begin
            n_err++;
            $display("FAIL page_awaddr: got n=%0d %h %h want 2 bc000ff0 bc001000",
                     aw_cnt, aw_addr_log[0], aw_addr_log[1]);
        end
        n_vec++;
        if ({aw_len_log[0], aw_len_log[1]} !== {8'd3, 8'd3}) begin
            n_err++;
            $display("FAIL page_awlen: got %0d %0d want 3 3", aw_len_log[0], aw_len_log[1]);
        end
        n_vec++;
        if (w_cnt !== 8 || data_err !== 0) begin
            n_err++; $display("FAIL page_wdata: got beats=%0d bad=%0d want 8 0", w_cnt, data_err);
        end
    endtask

    task automatic test_phy_gate();
        clear_log();
        phy_init_done = 1'b0;
        start_cmd(32'h0000_0000, 16'd40);
        repeat (100) @(posedge clk);
        #1;
        n_vec++;
        if (awv_cycles !== 0) begin
            n_err++; $display("FAIL phy_gate_aw: got %0d awvalid cycles want 0", awv_cycles);
        end
        n_vec++;
        if (s_ready !== 1'b0) begin
            n_err++; $display("FAIL phy_gate_full: got s_ready=%b want 0", s_ready);
        end
        phy_init_done = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (awv_cycles == 0) begin
            n_err++; $display("FAIL phy_release_aw: got %0d awvalid cycles want >=1", awv_cycles);
        end
        wait_done(600);
        n_vec++;
        if (aw_cnt !== 3 || w_cnt !== 40 || data_err !== 0) begin
            n_err++;
            $display("FAIL phy_job: got aw=%0d beats=%0d bad=%0d want 3 40 0",
                     aw_cnt, w_cnt, data_err);
        end
    endtask

    task automatic test_backpressure();
        clear_log();
        rnd_en = 1'b1;
        start_cmd(32'h0000_0100, 16'd100);
        wait_done(4000);
        rnd_en = 1'b0;
        n_vec++;
        if (w_cnt !== 100 || data_err !== 0) begin
            n_err++; $display("FAIL bp_wdata: got beats=%0d bad=%0d want 100 0", w_cnt, data_err);
        end
        n_vec++;
        if (aw_cnt !== 7 || wlast_cnt !== 7) begin
            n_err++; $display("FAIL bp_bursts: got aw=%0d wlast=%0d want 7 7", aw_cnt, wlast_cnt);
        end
        n_vec++;
        if (aw_addr_log[6] !== 32'h0000_0280 || aw_len_log[6] !== 8'd3) begin
            n_err++;
            $display("FAIL bp_last_burst: got %h len %0d want 00000280 len 3",
                     aw_addr_log[6], aw_len_log[6]);
        end
        n_vec++;
        if (stab_err !== 0 || order_err !== 0) begin
            n_err++;
            $display("FAIL bp_protocol: got stab=%0d order=%0d want 0 0", stab_err, order_err);
        end
    endtask

    task automatic test_bresp_err();
        clear_log();
        err_burst = 1;
        start_cmd(32'hBC00_0000, 16'd40);
        wait_done(600);
        err_burst = -1;
        n_vec++;
        if (err !== 1'b1 || b_cnt !== 3) begin
            n_err++; $display("FAIL bresp_err_set: got err=%b b=%0d want 1 3", err, b_cnt);
        end
        clear_log();
        start_cmd(32'h0000_0000, 16'd0);
        n_vec++;
        if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL zero_job: got done=%b err=%b busy=%b want 1 0 0", done, err, busy);
        end
        wait_done(10);
    endtask

    task automatic test_async_reset();
        int t = 0;
        clear_log();
        start_cmd(32'h0000_0000, 16'd40);
        while (!m_axi_wvalid && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        #2;
        aresetn = 1'b0;
        #1;
        n_vec++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, busy, cmd_ready} !== 5'b0 || t >= 200) begin
            n_err++;
            $display("FAIL async_reset: got %b (wait %0d) want 00000",
                     {m_axi_awvalid, m_axi_wvalid, m_axi_bready, busy, cmd_ready}, t);
        end
        repeat (3) @(posedge clk);
        #1;
        aresetn = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (cmd_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_recover_ready: got %b want 1", cmd_ready);
        end
        clear_log();
        start_cmd(32'h0000_1000, 16'd4);
        wait_done(200);
        n_vec++;
        if (aw_cnt !== 1 || aw_addr_log[0] !== 32'h0000_1000 || aw_len_log[0] !== 8'd3) begin
            n_err++;
            $display("FAIL recover_aw: got n=%0d %h len %0d want 1 00001000 len 3",
                     aw_cnt, aw_addr_log[0], aw_len_log[0]);
        end
        n_vec++;
        if (w_cnt !== 4 || data_err !== 0) begin
            n_err++; $display("FAIL recover_wdata: got beats=%0d bad=%0d want 4 0", w_cnt, data_err);
        end
    endtask

    initial begin
        clear_log();
        test_reset();
        test_multi_burst();
        test_4k_boundary();
        test_phy_gate();
        test_backpressure();
        test_bresp_err();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ddr3_stream_writer.md
Name: ddr3_stream_writer

Overview:
- Upstream AXI4 write master feeding the DDR3 SDRAM controller's s_axi slave; converts the relaxation engine's 32-bit result stream into INCR write bursts to a contiguous DDR3 region.
- Buffers incoming words in an internal FIFO; issues a burst only once every beat of that burst is buffered, so WVALID never bubbles.
- Write-only; the AR/R channels are owned by a separate reader block.

Parameters:
- BURST_LEN, 16, maximum beats per AXI burst; power of two, 1..256
- FIFO_DEPTH, 32, data FIFO entries; power of two, >= BURST_LEN
- ID_VAL, 1'b0, constant driven on m_axi_awid

Ports:
- clk  in  1  single clock, shared with the controller AXI clock
- aresetn  in  1  asynchronous active-low reset
- phy_init_done  in  1  DDR3 calibration complete; no AW is issued while low
- cmd_valid  in  1  job request
- cmd_ready  out  1  high only in IDLE
- cmd_addr  in  32  byte start address; bits [1:0] ignored (treated as 0)
- cmd_beats  in  16  words in the job; 0 means complete immediately
- s_valid  in  1  data stream valid
- s_ready  out  1  FIFO not full and job active
- s_data  in  32  data word
- busy  out  1  job in progress
- done  out  1  one-cycle pulse when the last B response is accepted
- err  out  1  sticky; set by any BRESP != OKAY; cleared on the next accepted cmd
- m_axi_awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awqos  out  1/32/8/3/2/1/4/3/4  AW payload
- m_axi_awvalid  out  1
- m_axi_awready  in  1
- m_axi_wdata  out  32
- m_axi_wstrb  out  4
- m_axi_wlast  out  1
- m_axi_wvalid  out  1
- m_axi_wready  in  1
- m_axi_bid  in  1
- m_axi_bresp  in  2
- m_axi_bvalid  in  1
- m_axi_bready  out  1

Behaviour:
- Reset values: all valids 0, bready 0, busy 0, done 0, err 0, cmd_ready 0. cmd_ready rises 1 cycle after reset release. FIFO is emptied.
- Constants: awsize=3'b010, awburst=2'b01, awlock=0, awcache=4'b0011, awprot=0, awqos=0, wstrb=4'hF.
- States: IDLE, CALC, WAIT_FILL, ADDR, DATA, RESP.
- IDLE:
  - cmd_valid&cmd_ready latches addr and remaining=cmd_beats, clears err.
  - beats==0 -> done pulse the next cycle, stay in IDLE.
  - Otherwise -> CALC.
- CALC (1 cycle): blen = min(remaining, BURST_LEN, (4096 - addr[11:0])/4). Bursts never cross a 4KB boundary.
- WAIT_FILL: wait until fifo_count >= blen and phy_init_done=1 -> ADDR.
- ADDR: awvalid=1, awaddr=addr, awlen=blen-1. Hold the payload stable until awready; then -> DATA.
- DATA:
  - wvalid=1 while beats remain; data comes from the FIFO head.
  - wlast on beat blen-1. FIFO pops on wvalid&wready.
  - After the last handshake -> RESP.
- RESP:
  - bready=1. On bvalid: err|=(bresp!=0), addr+=blen*4, remaining-=blen.
  - remaining==0 -> done pulse, IDLE. Otherwise -> CALC.
- Single outstanding burst; W never precedes AW.
- s_ready = busy & !fifo_full.
  - Extra words beyond cmd_beats are never accepted: the total accepted count is capped at cmd_beats.
  - Simultaneous push/pop on a full FIFO is allowed.
- awaddr wraps modulo 2^32.
- Asynchronous reset mid-burst abandons the transaction. The controller is reset by the same aresetn, so no protocol repair is attempted.

Optional Feature:
- Macro DDR3_STREAM_WRITER_PERF_EN.
- When defined, adds outputs perf_busy_cycles[31:0] (cycles with busy=1) and perf_stall_cycles[31:0] (cycles with wvalid&!wready or awvalid&!awready).
  - Both clear on an accepted cmd and saturate at all-ones.
- When undefined, these ports and counters do not exist.

Decomposition:
- Package ddr3_axi_pkg:
  - AXI_SIZE_4B, AXI_BURST_INCR, AXI_RESP_OKAY, AXI_CACHE_BUF_MOD constants
  - state enum typedef
  - localparam PAGE_4K=4096
- Sub-module ddr3_wr_fifo: synchronous FIFO with push/pop/count/full/empty and async active-low reset. The count output drives WAIT_FILL.

Test Plan:
- cmd_addr=0xBC000000, beats=40, BURST_LEN=16, stream always valid -> bursts awlen 15,15,7 at 0xBC000000, 0xBC000040, 0xBC000080; exactly one done; err=0.
- cmd_addr=0xBC000FF0, beats=8 -> awaddr 0xBC000FF0 awlen 3, then 0xBC001000 awlen 3; no burst crosses 4KB.
- phy_init_done=0 with a full FIFO for 100 cycles -> no awvalid; raising it -> AW within 2 cycles.
- Random wready/awready/bvalid backpressure, beats=100 -> 100 W beats, data in order, wlast count = burst count, AW payload stable while stalled.
- bresp=2'b10 on burst 2 of 3 -> job completes, err=1 after done; the next cmd clears err.
- aresetn asserted mid-DATA -> all valids 0 asynchronously; after release cmd_ready=1 and a beats=4 job completes correctly.
